// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage LoongArch pipeline.
// It sits between the execute stage and the write-back stage. It takes the
// execute result bundle plus the synchronous data-SRAM read data and forms the
// final load result (ld.w / ld.b / ld.h / ld.bu / ld.hu). The SRAM presents
// read data for only one cycle, so the stage captures it locally when
// write-back stalls.
//
// Ports:
//   clk             in   single clock, rising edge
//   reset           in   asynchronous, active-high
//   ws_allowin      in   write-back can accept an instruction this cycle
//   ms_allowin      out  this stage can accept from execute
//   es_to_ms_valid  in   execute presents a valid bundle
//   es_to_ms_bus    in   {load_op[2:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}
//   data_sram_rdata in   SRAM read data, valid the cycle after the request
//   ms_to_ws_valid  out  valid bundle offered to write-back
//   ms_to_ws_bus    out  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
//   ms_to_ds_dest   out  forwarded destination register (0 when nothing writes)
//   ms_to_ds_value  out  forwarded final result (0 when nothing writes)
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [73:0] es_to_ms_bus,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [4:0]  ms_to_ds_dest,
    output logic [31:0] ms_to_ds_value
);

    logic        ms_valid_q,    ms_valid_d;
    logic [73:0] bus_q,         bus_d;
    logic [31:0] rdata_buf_q,   rdata_buf_d;
    logic        buf_valid_q,   buf_valid_d;
    logic        first_cycle_q, first_cycle_d;

    logic [2:0]  load_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic [31:0] raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] final_result;
    logic        fwd_en;

    assign {load_op, res_from_mem, gr_we, dest, alu_result, pc} = bus_q;

    // The stage never needs extra cycles, so only write-back back-pressure blocks entry.
    assign ms_allowin     = !ms_valid_q || ws_allowin;
    assign ms_to_ws_valid = ms_valid_q;

    always_comb begin
        ms_valid_d    = ms_valid_q;
        bus_d         = bus_q;
        rdata_buf_d   = rdata_buf_q;
        buf_valid_d   = buf_valid_q;
        first_cycle_d = 1'b0;

        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        if (ms_allowin && es_to_ms_valid) begin
            bus_d         = es_to_ms_bus;
            first_cycle_d = 1'b1;
            buf_valid_d   = 1'b0;
        end else if (ms_valid_q && first_cycle_q && !ws_allowin) begin
            // Last chance to grab the SRAM data before it disappears.
            rdata_buf_d = data_sram_rdata;
            buf_valid_d = 1'b1;
        end else if (ms_valid_q && ws_allowin) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            bus_q         <= '0;
            rdata_buf_q   <= '0;
            buf_valid_q   <= 1'b0;
            first_cycle_q <= 1'b0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            bus_q         <= bus_d;
            rdata_buf_q   <= rdata_buf_d;
            buf_valid_q   <= buf_valid_d;
            first_cycle_q <= first_cycle_d;
        end
    end

    always_comb begin
        raw = buf_valid_q ? rdata_buf_q : data_sram_rdata;

        case (alu_result[1:0])
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase

        // Halfword lane ignores address bit 0; misalignment is trapped upstream.
        half_sel = alu_result[1] ? raw[31:16] : raw[15:0];

        case (load_op)
            3'b001:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b011:  load_val = {24'd0, byte_sel};
            3'b100:  load_val = {16'd0, half_sel};
            default: load_val = raw;
        endcase

        final_result = res_from_mem ? load_val : alu_result;
    end

    // bus_q keeps stale contents after a bubble, so every output is gated by ms_valid_q.
    assign fwd_en         = ms_valid_q && gr_we;
    assign ms_to_ws_bus   = ms_valid_q ? {gr_we, dest, final_result, pc} : 70'd0;
    assign ms_to_ds_dest  = fwd_en ? dest : 5'd0;
    assign ms_to_ds_value = fwd_en ? final_result : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed load cases followed by randomized traffic.
// Each accepted instruction pushes its expected write-back bundle into a queue;
// a monitor on the falling edge compares whatever the stage presents against
// the head of that queue and pops it when write-back accepts.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [4:0]  ms_to_ds_dest;
    logic [31:0] ms_to_ds_value;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_ds_dest   (ms_to_ds_dest),
        .ms_to_ds_value  (ms_to_ds_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [69:0] bus;
        logic [4:0]  dest;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        else
            n_pass++;
    endtask

    function automatic logic [73:0] mk(input logic [2:0] op, input logic rfm, input logic we,
                                       input logic [4:0] dst, input logic [31:0] alu,
                                       input logic [31:0] pc);
        return {op, rfm, we, dst, alu, pc};
    endfunction

    // Reference load semantics written as shift/mask arithmetic on the word.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        int          bsh;
        int          hsh;
        logic [31:0] b;
        logic [31:0] h;
        bsh = 8 * int'(addr[1:0]);
        hsh = 16 * int'(addr[1]);
        b   = (w >> bsh) & 32'h0000_00FF;
        h   = (w >> hsh) & 32'h0000_FFFF;
        case (op)
            3'd1:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic exp_t ref_model(input logic [73:0] bus, input logic [31:0] w);
        exp_t        e;
        logic [31:0] fin;
        fin     = bus[70] ? ref_load(bus[73:71], bus[63:32], w) : bus[63:32];
        e.bus   = {bus[69], bus[68:64], fin, bus[31:0]};
        e.dest  = bus[69] ? bus[68:64] : 5'd0;
        e.value = bus[69] ? fin : 32'd0;
        return e;
    endfunction

    // Called just after a rising edge. Offers one cycle of stimulus; if the
    // stage is modelled as accepting, the SRAM word is returned next cycle.
    task automatic step(input logic v, input logic [73:0] bus, input logic ws,
                        input logic [31:0] word);
        logic acc;
        es_to_ms_valid = v;
        es_to_ms_bus   = bus;
        ws_allowin     = ws;
        acc = v && ((exp_q.size() == 0) || ws);
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        if (acc) begin
            exp_q.push_back(ref_model(bus, word));
            data_sram_rdata = word;
        end else begin
            data_sram_rdata = $urandom;
        end
    endtask

    task automatic check_now(input string name, input logic [31:0] fin,
                             input logic [4:0] dst, input logic [31:0] val);
        @(negedge clk);
        chk({name, "_result"}, {38'd0, ms_to_ws_bus[63:32]}, {38'd0, fin});
        chk({name, "_dest"},   {65'd0, ms_to_ds_dest},       {65'd0, dst});
        chk({name, "_value"},  {38'd0, ms_to_ds_value},      {38'd0, val});
        @(posedge clk);
        #1;
        data_sram_rdata = $urandom;
    endtask

    // Monitor: occupancy comes from the scoreboard, not from the DUT.
    always @(negedge clk) begin
        logic occ;
        occ = (exp_q.size() != 0);
        chk("mon_valid",   {69'd0, ms_to_ws_valid}, {69'd0, occ});
        chk("mon_allowin", {69'd0, ms_allowin},     {69'd0, (!occ || ws_allowin)});
        if (occ) begin
            chk("mon_bus",   ms_to_ws_bus,            exp_q[0].bus);
            chk("mon_dest",  {65'd0, ms_to_ds_dest},  {65'd0, exp_q[0].dest});
            chk("mon_value", {38'd0, ms_to_ds_value}, {38'd0, exp_q[0].value});
            if (ws_allowin) void'(exp_q.pop_front());
        end else begin
            chk("mon_idle_bus",   ms_to_ws_bus,            70'd0);
            chk("mon_idle_dest",  {65'd0, ms_to_ds_dest},  70'd0);
            chk("mon_idle_value", {38'd0, ms_to_ds_value}, 70'd0);
        end
    end

    initial begin
        logic [73:0] b;
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;
        @(posedge clk);
        #1;
        chk("rst_allowin", {69'd0, ms_allowin},     70'd1);
        chk("rst_valid",   {69'd0, ms_to_ws_valid}, 70'd0);
        chk("rst_bus",     ms_to_ws_bus,            70'd0);
        chk("rst_dest",    {65'd0, ms_to_ds_dest},  70'd0);
        chk("rst_value",   {38'd0, ms_to_ds_value}, 70'd0);
        reset = 1'b0;

        // ld.w, then a bubble.
        step(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd5, 32'h1000, 32'h1c00_0000), 1'b1, 32'h8899_AABB);
        check_now("ldw", 32'h8899_AABB, 5'd5, 32'h8899_AABB);
        @(negedge clk);
        chk("bubble_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        chk("bubble_dest",  {65'd0, ms_to_ds_dest},  70'd0);
        @(posedge clk);
        #1;

        // Byte and halfword lanes.
        step(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd6, 32'h1003, 32'h1c00_0010), 1'b1, 32'h8011_2233);
        check_now("ldb_b3", 32'hFFFF_FF80, 5'd6, 32'hFFFF_FF80);
        step(1'b1, mk(3'd3, 1'b1, 1'b1, 5'd7, 32'h1003, 32'h1c00_0014), 1'b1, 32'h8011_2233);
        check_now("ldbu_b3", 32'h0000_0080, 5'd7, 32'h0000_0080);
        step(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd8, 32'h1001, 32'h1c00_0018), 1'b1, 32'h8011_2233);
        check_now("ldb_b1", 32'h0000_0022, 5'd8, 32'h0000_0022);
        step(1'b1, mk(3'd2, 1'b1, 1'b1, 5'd9, 32'h1002, 32'h1c00_001c), 1'b1, 32'h8001_1234);
        check_now("ldh_h1", 32'hFFFF_8001, 5'd9, 32'hFFFF_8001);
        step(1'b1, mk(3'd4, 1'b1, 1'b1, 5'd10, 32'h1002, 32'h1c00_0020), 1'b1, 32'h8001_1234);
        check_now("ldhu_h1", 32'h0000_8001, 5'd10, 32'h0000_8001);
        step(1'b1, mk(3'd2, 1'b1, 1'b1, 5'd11, 32'h1000, 32'h1c00_0024), 1'b1, 32'h8001_1234);
        check_now("ldh_h0", 32'h0000_1234, 5'd11, 32'h0000_1234);

        // Non-load with gr_we = 0: result is alu_result, forwarding masked.
        step(1'b1, mk(3'd0, 1'b0, 1'b0, 5'd12, 32'h1234_5678, 32'h1c00_0028), 1'b1, 32'hFFFF_FFFF);
        check_now("nonload", 32'h1234_5678, 5'd0, 32'd0);

        // Stall hold: three stalled cycles, SRAM data changes after the first,
        // then the stalled ld.w leaves while the queued ld.b enters.
        step(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd13, 32'h2000, 32'h1c00_0030), 1'b1, 32'h1111_1111);
        b = mk(3'd1, 1'b1, 1'b1, 5'd14, 32'h2001, 32'h1c00_0034);
        step(1'b1, b, 1'b0, 32'h0000_5500);
        data_sram_rdata = 32'hDEAD_BEEF;
        step(1'b1, b, 1'b0, 32'h0000_5500);
        data_sram_rdata = 32'hDEAD_BEEF;
        step(1'b1, b, 1'b0, 32'h0000_5500);
        data_sram_rdata = 32'hDEAD_BEEF;
        step(1'b1, b, 1'b1, 32'h0000_5500);
        check_now("stall_next", 32'h0000_0055, 5'd14, 32'h0000_0055);

        // Reset during the second stalled cycle, then a fresh ld.hu.
        step(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd15, 32'h3000, 32'h1c00_0040), 1'b1, 32'hCAFE_F00D);
        step(1'b0, '0, 1'b0, 32'd0);
        data_sram_rdata = 32'h7777_7777;
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_mid_valid",   {69'd0, ms_to_ws_valid}, 70'd0);
        chk("rst_mid_dest",    {65'd0, ms_to_ds_dest},  70'd0);
        chk("rst_mid_value",   {38'd0, ms_to_ds_value}, 70'd0);
        chk("rst_mid_allowin", {69'd0, ms_allowin},     70'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, mk(3'd4, 1'b1, 1'b1, 5'd16, 32'h3002, 32'h1c00_0044), 1'b0, 32'hA5A5_7E57);
        check_now("post_rst_ldhu", 32'h0000_A5A5, 5'd16, 32'h0000_A5A5);
        step(1'b0, '0, 1'b1, 32'd0);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0,
                 mk(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 5'($urandom),
                    $urandom, $urandom),
                 ($urandom % 3) != 0,
                 $urandom);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, between the execute stage and the write-back stage. It takes the execute stage's result bundle and the synchronous data SRAM read data, then forms the final load result: word, signed byte, unsigned byte, signed halfword or unsigned halfword. It forwards the destination register and value to decode for hazard handling. It holds the read data locally when write-back stalls, because the SRAM returns data for only one cycle.

## Interface
- Parameters: none.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `ws_allowin` in 1: write-back stage can accept an instruction this cycle.
- `ms_allowin` out 1: this stage can accept an instruction from execute.
- `es_to_ms_valid` in 1: execute presents a valid bundle.
- `es_to_ms_bus` in 74: fields are:
  - load_op [73:71]
  - res_from_mem [70]
  - gr_we [69]
  - dest [68:64]
  - alu_result [63:32], which is also the memory address
  - pc [31:0]
- `data_sram_rdata` in 32: SRAM read data, valid in the cycle after the request.
- `ms_to_ws_valid` out 1: valid bundle offered to write-back.
- `ms_to_ws_bus` out 70: fields are gr_we [69], dest [68:64], final_result [63:32], pc [31:0].
- `ms_to_ds_dest` out 5: destination of the in-flight writing instruction; 0 otherwise.
- `ms_to_ds_value` out 32: final_result of that instruction; 0 otherwise.

## Operation
- State:
  - `ms_valid`
  - `bus_r` (74 b)
  - `rdata_buf` (32 b)
  - `buf_valid`
  - `first_cycle`: set on entry, cleared after one cycle.
- Handshake:
  - `ms_ready_go` = 1.
  - `ms_allowin` = !ms_valid || ws_allowin.
  - `ms_to_ws_valid` = ms_valid.
- Entry: on `ms_allowin`, `ms_valid` <= `es_to_ms_valid`. If `es_to_ms_valid` is also 1:
  - `bus_r` <= `es_to_ms_bus`
  - `first_cycle` <= 1
  - `buf_valid` <= 0
- Read-data hold:
  - Capture: when ms_valid && first_cycle && !ws_allowin, `rdata_buf` <= `data_sram_rdata` and `buf_valid` <= 1.
  - Clear: `buf_valid` clears when the instruction leaves (ms_valid && ws_allowin) or a new one enters.
  - Selection: raw = buf_valid ? rdata_buf : data_sram_rdata.
- Load extraction. Byte lane = alu_result[1:0]; half lane = alu_result[1], with alu_result[0] ignored and no alignment check here.
  - load_op 000: ld.w, raw.
  - 001: ld.b, sign-extend the selected byte.
  - 010: ld.h, sign-extend the selected half.
  - 011: ld.bu, zero-extend the selected byte.
  - 100: ld.hu, zero-extend the selected half.
  - 101–111: treated as ld.w.
- final_result = res_from_mem ? extracted load value : alu_result.
- Forwarding: `ms_to_ds_dest` = (ms_valid && gr_we) ? dest : 0; `ms_to_ds_value` is masked by the same condition.

## Timing
- Reset (async, immediate):
  - Registers cleared: ms_valid = 0, bus_r = 0, buf_valid = 0, rdata_buf = 0, first_cycle = 0.
  - Resulting outputs: ms_allowin = 1, ms_to_ws_valid = 0, ms_to_ws_bus = 0, ms_to_ds_dest = 0, ms_to_ds_value = 0.
- Latency: zero added cycles. An instruction latched at edge N drives its final result combinationally during cycle N..N+1 from bus_r and the current-cycle `data_sram_rdata`.
- Stall: while ms_valid && !ws_allowin, the bundle and final_result are stable. From the second stalled cycle, final_result comes from `rdata_buf`, independent of `data_sram_rdata`.
- Entry and exit together: when ws_allowin = 1, the old instruction leaves and the new one enters on the same edge.
- Bubble: when es_to_ms_valid = 0 and ms_allowin = 1, ms_valid falls at the next edge. bus_r is unchanged but is masked in every output.
- Reset mid-stall: the instruction is dropped and the buffer is invalidated with no edge required. The first post-reset entry behaves as a fresh entry.

## Test plan
- **ld.w:** ld.w at addr 0x1000, rdata = 0x8899AABB, ws_allowin = 1, dest = 5, gr_we = 1.
  - Required: ms_to_ws_bus[63:32] = 0x8899AABB, ms_to_ds_dest = 5, ms_to_ds_value = 0x8899AABB.
  - One cycle later, with es_to_ms_valid = 0: ms_to_ws_valid = 0 and ms_to_ds_dest = 0.
- **Byte loads:** addr 0x1003, rdata 0x80112233.
  - ld.b -> 0xFFFFFF80; ld.bu -> 0x00000080.
  - addr 0x1001, same rdata: ld.b -> 0x00000022.
- **Halfword loads:** addr 0x1002, rdata 0x80011234.
  - ld.h -> 0xFFFF8001; ld.hu -> 0x00008001.
  - addr 0x1000: ld.h -> 0x00001234.
- **Stall hold:** ld.w enters with rdata = 0x11111111; ws_allowin = 0 for 3 cycles; rdata changes to 0xDEADBEEF after the first cycle.
  - Required: result stays 0x11111111 and ms_allowin = 0 throughout.
  - When ws_allowin = 1, the instruction leaves and the next queued instruction enters on the same edge.
- **Non-load:** res_from_mem = 0, alu_result = 0x12345678, rdata = 0xFFFFFFFF -> final_result = 0x12345678.
  - With gr_we = 0: ms_to_ds_dest = 0 and ms_to_ds_value = 0.
- **Reset mid-stall:** assert reset asynchronously during cycle 2 of a stall.
  - Required: ms_to_ws_valid and ms_to_ds_* go to 0 before the next edge and ms_allowin = 1.
  - After release, a fresh ld.hu returns the current-cycle rdata, not stale buffer contents.
